// File: rtl/bus_loader.sv
// Boot-time bus initiator: holds the 6502 in reset and copies a byte stream into RAM from BASE_ADDR upward.
// Optional read-back verify of every byte is built when LOADER_VERIFY_EN is defined.
module bus_loader #(
  parameter int unsigned           ADDR_W        = 19,
  parameter logic [ADDR_W-1:0]     BASE_ADDR     = '0,
  parameter int unsigned           STROBE_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       length,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_dout,
  input  logic [7:0]        bus_din,
  output logic              bus_rw,
  output logic              ram_we_n,
  output logic              ram_oe_n,
  output logic              bus_own,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_VRD,
    S_VCHK,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_remaining;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_in_ready;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [7:0]        r_bus_dout;
  logic              r_bus_rw;
  logic              r_ram_we_n;
  logic              r_bus_own;
  logic              r_cpu_reset_n;
  logic              r_busy;
  logic              r_done;

  logic w_start_acc;
  logic w_byte_acc;
  logic w_cnt_last;
  logic w_last;
  logic w_advance;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_byte_acc  = (r_state == S_FETCH) && in_valid && r_in_ready;
  assign w_cnt_last  = (r_cnt == CNT_LAST);
  assign w_last      = (r_remaining == 16'd1);

`ifdef LOADER_VERIFY_EN
  // Counter/address advance once the read-back has been checked.
  assign w_advance = (r_state == S_VCHK);
`else
  assign w_advance = (r_state == S_HOLD);
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (length == 16'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_byte_acc) begin
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_STROBE;
      end
      S_STROBE: begin
        if (w_cnt_last) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
`ifdef LOADER_VERIFY_EN
        w_state_nxt = S_VRD;
`else
        w_state_nxt = w_last ? S_DONE : S_FETCH;
`endif
      end
`ifdef LOADER_VERIFY_EN
      S_VRD: begin
        if (w_cnt_last) begin
          w_state_nxt = S_VCHK;
        end
      end
      S_VCHK: begin
        w_state_nxt = w_last ? S_DONE : S_FETCH;
      end
`endif
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Strobe-width counter, restarted on every state change
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if ((r_state == S_STROBE) || (r_state == S_VRD)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Bus outputs are registered from the next state so they line up with it
  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_ready    <= 1'b0;
      r_bus_addr    <= BASE_ADDR;
      r_bus_dout    <= 8'h00;
      r_bus_rw      <= 1'b1;
      r_ram_we_n    <= 1'b1;
      r_bus_own     <= 1'b0;
      r_cpu_reset_n <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_remaining   <= 16'd0;
    end else begin
      r_in_ready <= (w_state_nxt == S_FETCH);
      r_bus_rw   <= !(w_state_nxt inside {S_SETUP, S_STROBE, S_HOLD});
      r_ram_we_n <= (w_state_nxt != S_STROBE);
      r_bus_own  <= !(w_state_nxt inside {S_IDLE, S_DONE});
      r_busy     <= !(w_state_nxt inside {S_IDLE, S_DONE});

      if (w_start_acc) begin
        r_remaining   <= length;
        r_bus_addr    <= BASE_ADDR;
        r_done        <= 1'b0;
        r_cpu_reset_n <= 1'b0;
      end
      // Zero-length loads go straight to DONE, so this must follow the start update
      if (w_state_nxt == S_DONE) begin
        r_done        <= 1'b1;
        r_cpu_reset_n <= 1'b1;
      end
      if (w_byte_acc) begin
        r_bus_dout <= in_data;
      end
      if (w_advance) begin
        r_remaining <= r_remaining - 16'd1;
        if (!w_last) begin
          r_bus_addr <= r_bus_addr + ADDR_W'(1);
        end
      end
    end
  end

`ifdef LOADER_VERIFY_EN
  logic       r_ram_oe_n;
  logic       r_error;
  logic [7:0] r_rd_data;

  // Read-back path: capture on the last output-enable cycle, compare in VCHK
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ram_oe_n <= 1'b1;
      r_error    <= 1'b0;
      r_rd_data  <= 8'h00;
    end else begin
      r_ram_oe_n <= (w_state_nxt != S_VRD);
      if ((r_state == S_VRD) && w_cnt_last) begin
        r_rd_data <= bus_din;
      end
      if (w_start_acc) begin
        r_error <= 1'b0;
      end else if ((r_state == S_VCHK) && (r_rd_data != r_bus_dout)) begin
        r_error <= 1'b1;
      end
    end
  end

  assign ram_oe_n = r_ram_oe_n;
  assign error    = r_error;
`else
  logic w_unused_din;

  assign w_unused_din = ^bus_din;
  assign ram_oe_n     = 1'b1;
  assign error        = 1'b0;
`endif

  assign in_ready    = r_in_ready;
  assign bus_addr    = r_bus_addr;
  assign bus_dout    = r_bus_dout;
  assign bus_rw      = r_bus_rw;
  assign ram_we_n    = r_ram_we_n;
  assign bus_own     = r_bus_own;
  assign cpu_reset_n = r_cpu_reset_n;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_bus_loader.sv
// Bench for bus_loader: a base-0 instance with a small RAM model and a base-7FFFF instance for wrap.
// Table-driven loads plus hand sequences for zero length, start-in-DONE, reset mid-byte and verify.
module tb_bus_loader;

  localparam int unsigned S = 2;
`ifdef LOADER_VERIFY_EN
  localparam int PER_BYTE = 2 * S + 4;
`else
  localparam int PER_BYTE = S + 3;
`endif
  localparam logic [18:0] BASE0 = 19'h00000;
  localparam logic [18:0] BASE1 = 19'h7FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [15:0] length = 16'd0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        corrupt = 1'b0;

  logic        in_ready0, rw0, we0, oe0, own0, crst0, busy0, done0, err0;
  logic [18:0] addr0;
  logic [7:0]  dout0, din0;
  logic        in_ready1, rw1, we1, oe1, own1, crst1, busy1, done1, err1;
  logic [18:0] addr1;
  logic [7:0]  dout1, din1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  bus_loader #(.ADDR_W(19), .BASE_ADDR(BASE0), .STROBE_CYCLES(S)) u_dut (
    .clock(clk), .reset(reset), .start(start0), .length(length),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .bus_addr(addr0), .bus_dout(dout0), .bus_din(din0), .bus_rw(rw0),
    .ram_we_n(we0), .ram_oe_n(oe0), .bus_own(own0), .cpu_reset_n(crst0),
    .busy(busy0), .done(done0), .error(err0)
  );

  bus_loader #(.ADDR_W(19), .BASE_ADDR(BASE1), .STROBE_CYCLES(S)) u_dut_wrap (
    .clock(clk), .reset(reset), .start(start1), .length(length),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .bus_addr(addr1), .bus_dout(dout1), .bus_din(din1), .bus_rw(rw1),
    .ram_we_n(we1), .ram_oe_n(oe1), .bus_own(own1), .cpu_reset_n(crst1),
    .busy(busy1), .done(done1), .error(err1)
  );

  // RAM model for the base-0 instance; corrupt flips a bit on read of address 1
  logic [7:0] ram0 [16];
  always @(posedge clk) if (!we0) ram0[addr0[3:0]] <= dout0;
  assign din0 = ram0[addr0[3:0]] ^ ((corrupt && addr0 == 19'd1) ? 8'h40 : 8'h00);
  assign din1 = dout1;

  typedef struct packed {
    logic [18:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t  log0[$];
  wr_t  log1[$];
  logic pw0 = 1'b1;
  logic pw1 = 1'b1;

  // Write-pulse logger and strobe/direction invariants
  always @(posedge clk) begin
    cyc++;
    pw0 <= we0;
    pw1 <= we1;
    if (!we0 && pw0) log0.push_back({addr0, dout0});
    if (!we1 && pw1) log1.push_back({addr1, dout1});
    if (!reset) begin
      checks++;
      if ((!we0 && !oe0) || (!we0 && rw0) || (!we1 && rw1)) begin
        errors++;
        $display("FAIL strobe_invariant at cycle %0d: we0=%b oe0=%b rw0=%b we1=%b rw1=%b",
                 cyc, we0, oe0, rw0, we1, rw1);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel != 0) ? in_ready1 : in_ready0;
  endfunction

  function automatic logic dn(input int sel);
    return (sel != 0) ? done1 : done0;
  endfunction

  typedef struct {
    logic [15:0]      len;
    logic [3:0][7:0]  data;
    int               gap;
    bit               mid_start;
    bit               exp_err;
  } vec_t;

  task automatic run_load(input int sel, input vec_t v);
    int   n;
    int   t_prev;
    int   t_now;
    wr_t  e;
    logic [18:0] base;
    base = (sel != 0) ? BASE1 : BASE0;
    if (sel == 0) log0.delete(); else log1.delete();
    @(negedge clk);
    length = v.len;
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    t_prev = 0;
    for (int i = 0; i < int'(v.len); i++) begin
      for (int g = 0; g < v.gap; g++) begin
        if (v.mid_start && i == 1 && g == 0) start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
      end
      in_data  = v.data[i];
      in_valid = 1'b1;
      n = 0;
      while (!rdy(sel) && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) chk("byte_accept_timeout", 32'(n), 32'(0));
      t_now = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      if (v.gap == 0 && i > 0) chk("in_ready_spacing", 32'(t_now - t_prev), 32'(PER_BYTE));
      t_prev = t_now;
    end
    n = 0;
    while (!dn(sel) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("done_timeout", 32'(n), 32'(0));
    if (sel == 0) begin
      chk("done", 32'(done0), 32'(1));
      chk("cpu_reset_n", 32'(crst0), 32'(1));
      chk("bus_own", 32'(own0), 32'(0));
      chk("busy", 32'(busy0), 32'(0));
      chk("error", 32'(err0), 32'(v.exp_err));
      chk("write_count", 32'(log0.size()), 32'(v.len));
    end else begin
      chk("wrap_done", 32'(done1), 32'(1));
      chk("wrap_cpu_reset_n", 32'(crst1), 32'(1));
      chk("wrap_write_count", 32'(log1.size()), 32'(v.len));
    end
    for (int k = 0; k < int'(v.len); k++) begin
      if (sel == 0 && k < log0.size()) e = log0[k];
      else if (sel != 0 && k < log1.size()) e = log1[k];
      else e = '1;
      chk("write_addr", 32'(e.a), 32'(19'(base + 19'(k))));
      chk("write_data", 32'(e.d), 32'(v.data[k]));
    end
  endtask

  vec_t tbl[5];
  vec_t v;
  int   n;

  initial begin
    tbl[0] = '{16'd3, {8'h00, 8'hFF, 8'h5A, 8'hA5}, 0, 1'b0, 1'b0};
    tbl[1] = '{16'd2, {8'h00, 8'h00, 8'h34, 8'h12}, 7, 1'b1, 1'b0};
    tbl[2] = '{16'd4, {8'h7E, 8'h80, 8'h01, 8'h00}, 0, 1'b0, 1'b0};
    tbl[3] = '{16'd1, {8'h00, 8'h00, 8'h00, 8'hC3}, 3, 1'b0, 1'b0};
    tbl[4] = '{16'd3, {8'h00, 8'h99, 8'h88, 8'h77}, 7, 1'b1, 1'b0};

    // Reset, then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_cpu_reset_n", 32'(crst0), 32'(0));
    chk("rst_bus_own", 32'(own0), 32'(0));
    chk("rst_ram_we_n", 32'(we0), 32'(1));
    chk("rst_ram_oe_n", 32'(oe0), 32'(1));
    chk("rst_done", 32'(done0), 32'(0));
    chk("rst_busy", 32'(busy0), 32'(0));
    chk("rst_in_ready", 32'(in_ready0), 32'(0));
    chk("rst_bus_rw", 32'(rw0), 32'(1));
    chk("rst_bus_addr", 32'(addr0), 32'(BASE0));
    chk("rst_bus_dout", 32'(dout0), 32'(0));
    chk("rst_error", 32'(err0), 32'(0));
    chk("rst_wrap_addr", 32'(addr1), 32'(BASE1));

    for (int i = 0; i < 5; i++) run_load(0, tbl[i]);

    // Zero-length load: DONE on the cycle after start, then a start in DONE is ignored
    log0.delete();
    @(negedge clk);
    length = 16'd0;
    start0 = 1'b1;
    @(negedge clk);
    length = 16'd2;
    chk("len0_done", 32'(done0), 32'(1));
    chk("len0_cpu_reset_n", 32'(crst0), 32'(1));
    chk("len0_busy", 32'(busy0), 32'(0));
    @(negedge clk);
    start0 = 1'b0;
    chk("start_in_done_busy", 32'(busy0), 32'(0));
    chk("start_in_done_ready", 32'(in_ready0), 32'(0));
    repeat (5) @(negedge clk);
    chk("start_in_done_busy_late", 32'(busy0), 32'(0));
    chk("len0_no_writes", 32'(log0.size()), 32'(0));
    chk("len0_done_sticky", 32'(done0), 32'(1));

    // Wrap from the top of the address space
    v = '{16'd2, {8'h00, 8'h00, 8'h22, 8'h11}, 0, 1'b0, 1'b0};
    run_load(1, v);
    if (log1.size() == 2) chk("wrap_second_addr", 32'(log1[1].a), 32'(0));

`ifdef LOADER_VERIFY_EN
    corrupt = 1'b1;
    v = '{16'd3, {8'h00, 8'h33, 8'h22, 8'h11}, 0, 1'b0, 1'b1};
    run_load(0, v);
    corrupt = 1'b0;
`endif

    // Reset in the middle of a write strobe
    log0.delete();
    @(negedge clk);
    length = 16'd3;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    in_data  = 8'hA1;
    in_valid = 1'b1;
    n = 0;
    while (we0 && n < 50) begin
      @(negedge clk);
      in_valid = in_ready0;
      n++;
    end
    in_valid = 1'b0;
    chk("mid_reset_strobe_reached", 32'(we0), 32'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_we_n", 32'(we0), 32'(1));
    chk("mid_reset_cpu_reset_n", 32'(crst0), 32'(0));
    chk("mid_reset_bus_own", 32'(own0), 32'(0));
    chk("mid_reset_busy", 32'(busy0), 32'(0));
    chk("mid_reset_done", 32'(done0), 32'(0));
    chk("mid_reset_addr", 32'(addr0), 32'(BASE0));
    chk("mid_reset_rw", 32'(rw0), 32'(1));
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("after_reset_writes", 32'(log0.size()), 32'(1));
    chk("after_reset_busy", 32'(busy0), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
